serial_link_master: RTL
=======================

Name: serial_link_master

Overview:
- Initiator end of the team's 3-wire framed serial link. Drives chip-select, start strobe and MOSI data toward a responder, then captures the responder's framed reply on MISO.
- Sits between a byte-level command source (valid/ready) and the pad-facing link wires.
- Lets the responder side be exercised on-chip and from the bench.

Parameters:
- DATA_W, 8, payload bits per frame, sent and received MSB first.
- TIMEOUT, 32, cycles to wait for the MISO start bit before aborting; minimum 2.

Ports:
- clk  in  1  system clock; all outputs change on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_valid  in  1  request to send tx_data.
- tx_data  in  DATA_W  byte to transmit.
- tx_ready  out  1  high only in IDLE; transfer accepted when tx_valid and tx_ready are both high.
- rx_valid  out  1  one-cycle pulse when a transaction completes, including on error.
- rx_data  out  DATA_W  captured response byte; valid when rx_valid is high; held until the next completion.
- rx_err  out  2  completion status, qualified by rx_valid: 0=ok, 1=timeout, 2=framing (stop bit 0), 3=mismatch (see Optional Feature).
- busy  out  1  high from accept until the cycle after the rx_valid pulse.
- cs_n  out  1  link chip-select, active low.
- start_n  out  1  link start strobe, active low.
- mosi  out  1  link data out.
- miso  in  1  link data in; idle level is 1; synchronised internally by a 2-flop synchroniser.

Behaviour:
- Reset values (asynchronous): cs_n=1, start_n=1, mosi=0, tx_ready=1, rx_valid=0, rx_data=0, rx_err=0, busy=0. FSM goes to IDLE and all counters clear.
- Reset asserted mid-transaction aborts immediately. Link outputs return to idle, and no rx_valid pulse is produced.
- States: IDLE, SEL, START, SEND, WAIT, RECV, STOP, DONE.
- IDLE: tx_ready=1. On accept, latch tx_data into the shift register and go to SEL.
- SEL (1 cycle): cs_n=0.
- START (1 cycle): start_n=0 for exactly this cycle; otherwise start_n=1.
- SEND (DATA_W cycles): mosi = shift register MSB, shifting left each cycle. After DATA_W cycles go to WAIT, with mosi=0.
  - Line timing: cs_n falls at cycle C, start_n is low in C+1, data bits occupy C+2..C+1+DATA_W. The responder samples on the falling edge, mid-cycle.
- WAIT: cs_n stays low. Go to RECV on the first cycle where synchronised miso==0 (the start bit).
  - The timeout counter counts WAIT cycles. When it reaches TIMEOUT with no start bit, go to DONE with err=1 and rx_data unchanged.
- RECV (DATA_W cycles): sample synchronised miso into the receive shifter, MSB first, one bit per cycle, starting the cycle after the start bit was detected.
- STOP (1 cycle): sample miso. 1 means ok; 0 means err=2. rx_data is still updated with the captured byte.
- DONE (1 cycle): cs_n=1, rx_valid=1, rx_err set, then back to IDLE. cs_n therefore stays high for at least 1 idle cycle between frames.
- tx_valid while busy is ignored; it is not queued.
- A miso low seen before WAIT is ignored.
- Latency with an ok reply: rx_valid pulses exactly 2+DATA_W+W+DATA_W+2 cycles after accept, where W = WAIT cycles before the start bit is detected.

Optional Feature:
- Macro SERIAL_LINK_ECHO_CHECK_EN.
- When defined: keeps a copy of the transmitted byte. On an otherwise-ok completion, if rx_data differs from the sent byte, report rx_err=3. This serves the echo responder.
- When undefined: no copy register, and rx_err never takes value 3.
- Timeout and framing errors take priority over mismatch.

Decomposition:
- Shared package holds:
  - state enum (IDLE..DONE);
  - rx_err code constants ERR_OK/ERR_TIMEOUT/ERR_FRAME/ERR_MISMATCH;
  - link idle-level constants.
- One sub-module: serial_link_sync2 (2-flop synchroniser with asynchronous reset, preset to 1) for miso.
- Shift registers and the timeout counter stay in the top module.

Test Plan:
- Echo responder model (start bit 2 cycles after the last MOSI bit), send 0xA9 -> MOSI bits 1,0,1,0,1,0,0,1 on C+2..C+9; rx_valid pulses once with rx_data=0xA9, rx_err=0; cs_n high the cycle after.
- MISO held at 1, send 0x3C, TIMEOUT=32 -> rx_valid with rx_err=1 after exactly 32 WAIT cycles; rx_data keeps its previous value; cs_n released.
- Responder returns 0x55 with stop bit 0 -> rx_data=0x55, rx_err=2.
- SERIAL_LINK_ECHO_CHECK_EN defined, send 0x0F, responder returns 0xF0 -> rx_err=3. Same stimulus with the macro undefined -> rx_err=0.
- rst_n pulled low during SEND of 0xFF -> cs_n=1, start_n=1, mosi=0 asynchronously; no rx_valid pulse; the next accept starts a clean frame.
- tx_valid held high continuously with back-to-back bytes 0x01, 0x02 -> second accept occurs only after DONE; exactly one rx_valid per byte, in order.

Source files
------------

// File: rtl/serial_link_master_pkg.sv
// serial_link_master_pkg
//   Shared definitions for the framed serial link initiator:
//   - state_t      : initiator FSM states (IDLE..DONE)
//   - ERR_*        : rx_err completion codes
//   - *_IDLE       : quiescent levels of the link wires
package serial_link_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    START,
    SEND,
    WAIT,
    RECV,
    STOP,
    DONE
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_FRAME    = 2'd2;
  localparam logic [1:0] ERR_MISMATCH = 2'd3;

  localparam logic CS_IDLE    = 1'b1;
  localparam logic START_IDLE = 1'b1;
  localparam logic MOSI_IDLE  = 1'b0;
  localparam logic MISO_IDLE  = 1'b1;

endpackage

// File: rtl/serial_link_sync2.sv
// serial_link_sync2
//   Two-flop synchroniser for the MISO line. Both flops preset to the
//   idle level of the line so a reset never looks like a start bit.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input
//   q      out  synchronised output (2 clk latency)
module serial_link_sync2
  import serial_link_master_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= MISO_IDLE;
      q        <= MISO_IDLE;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/serial_link_master.sv
// serial_link_master
//   Initiator end of the 3-wire framed serial link. Accepts a byte on a
//   valid/ready interface, sends a frame (cs_n low, one-cycle start_n
//   strobe, DATA_W bits MSB first on mosi), then waits for the responder's
//   reply on miso: a low start bit, DATA_W data bits MSB first and a high
//   stop bit. Completion is reported with a one-cycle rx_valid pulse.
// Parameters:
//   DATA_W   payload bits per frame
//   TIMEOUT  WAIT cycles allowed before the start bit (>= 2)
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tx_valid/tx_data    byte to send; tx_ready high only when idle
//   rx_valid/rx_data    completion pulse and captured reply byte
//   rx_err              0 ok, 1 timeout, 2 framing, 3 echo mismatch
//   busy                high from accept until the cycle after rx_valid
//   cs_n/start_n/mosi   link outputs
//   miso                link input (idle high, synchronised internally)
// Build option:
//   SERIAL_LINK_ECHO_CHECK_EN  compare the reply with the sent byte and
//                              report ERR_MISMATCH on a difference.
module serial_link_master
  import serial_link_master_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic [1:0]        rx_err,
  output logic              busy,
  output logic              cs_n,
  output logic              start_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TO_CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_W - 1);
  localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(TIMEOUT - 1);

  state_t                state_reg;
  logic [DATA_W-1:0]     tx_shift_reg;
  logic [DATA_W-1:0]     rx_shift_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt_reg;
  logic [TO_CNT_W-1:0]   to_cnt_reg;
  logic                  miso_sync;
  logic                  echo_mismatch;
  logic [1:0]            ok_code;

  serial_link_sync2 u_miso_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (miso),
    .q     (miso_sync)
  );

`ifdef SERIAL_LINK_ECHO_CHECK_EN
  // The transmit shifter is consumed during SEND, so keep a copy of the
  // accepted byte for the echo comparison at STOP.
  logic [DATA_W-1:0] tx_copy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_copy_reg <= '0;
    end else if (state_reg == IDLE && tx_valid && tx_ready) begin
      tx_copy_reg <= tx_data;
    end
  end

  assign echo_mismatch = (rx_shift_reg != tx_copy_reg);
`else
  assign echo_mismatch = 1'b0;
`endif

  // Status for a reply whose stop bit was good.
  assign ok_code = echo_mismatch ? ERR_MISMATCH : ERR_OK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      bit_cnt_reg  <= '0;
      to_cnt_reg   <= '0;
      cs_n         <= CS_IDLE;
      start_n      <= START_IDLE;
      mosi         <= MOSI_IDLE;
      tx_ready     <= 1'b1;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_err       <= ERR_OK;
      busy         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift_reg <= tx_data;
            cs_n         <= 1'b0;
            tx_ready     <= 1'b0;
            busy         <= 1'b1;
            state_reg    <= SEL;
          end
        end

        SEL: begin
          start_n   <= 1'b0;
          state_reg <= START;
        end

        // First data bit goes out on the edge that ends the strobe.
        START: begin
          start_n      <= START_IDLE;
          mosi         <= tx_shift_reg[DATA_W-1];
          tx_shift_reg <= tx_shift_reg << 1;
          bit_cnt_reg  <= '0;
          state_reg    <= SEND;
        end

        SEND: begin
          if (bit_cnt_reg == BIT_LAST) begin
            mosi       <= MOSI_IDLE;
            to_cnt_reg <= '0;
            state_reg  <= WAIT;
          end else begin
            mosi         <= tx_shift_reg[DATA_W-1];
            tx_shift_reg <= tx_shift_reg << 1;
            bit_cnt_reg  <= bit_cnt_reg + BIT_CNT_W'(1);
          end
        end

        // A start bit in the last allowed cycle still wins over timeout.
        WAIT: begin
          if (!miso_sync) begin
            bit_cnt_reg <= '0;
            state_reg   <= RECV;
          end else if (to_cnt_reg == TO_LAST) begin
            cs_n      <= CS_IDLE;
            rx_valid  <= 1'b1;
            rx_err    <= ERR_TIMEOUT;
            state_reg <= DONE;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_CNT_W'(1);
          end
        end

        RECV: begin
          rx_shift_reg <= DATA_W'({rx_shift_reg, miso_sync});
          if (bit_cnt_reg == BIT_LAST) begin
            state_reg <= STOP;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
          end
        end

        // The byte is delivered even when the stop bit is bad.
        STOP: begin
          rx_data   <= rx_shift_reg;
          rx_err    <= miso_sync ? ok_code : ERR_FRAME;
          rx_valid  <= 1'b1;
          cs_n      <= CS_IDLE;
          state_reg <= DONE;
        end

        DONE: begin
          rx_valid  <= 1'b0;
          busy      <= 1'b0;
          tx_ready  <= 1'b1;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
